reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin write arbiter that shares one registered DATA_W-bit storage element (q/q_bar pair with write enable) between NUM_REQ requesters.
- Grants write ownership to one requester at a time and lets the owner perform up to MAX_HOLD consecutive writes.
- Acknowledges each committed write.
- Sits between multiple producer blocks and a single shared configuration/data register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, width of the shared register.
- MAX_HOLD, 3, max consecutive writes per grant (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request, level; bit i = requester i.
- data_in  input  NUM_REQ*DATA_W  write data; slice [i*DATA_W +: DATA_W] belongs to requester i.
- gnt  output  NUM_REQ  one-hot grant; at most one bit high.
- ack  output  NUM_REQ  one-cycle pulse; bit i high in the cycle after requester i's write committed.
- q  output  DATA_W  shared register contents.
- q_bar  output  DATA_W  bitwise complement of q.
- busy  output  1  high while in GRANT state.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, q=0, q_bar=all ones, gnt=0, ack=0, busy=0, hold_cnt=0, last=NUM_REQ-1 (requester 0 has first priority after reset).
- Reset mid-operation: any pending write is dropped and all state returns to reset values at that edge; reset has priority over every other event.
- States: IDLE, GRANT. gnt = onehot(owner) when state==GRANT, else 0; busy = (state==GRANT).
- IDLE edge, no req: stay IDLE.
- IDLE edge, any req bit high:
  - owner <= first requester with req high, searching last+1, last+2, ... modulo NUM_REQ.
  - hold_cnt <= 0; state <= GRANT.
  - gnt is visible the following cycle.
- GRANT edge, req[owner] high (write):
  - q <= data_in[owner]; q_bar <= ~data_in[owner] (same edge; q_bar never lags q).
  - ack <= onehot(owner); hold_cnt <= hold_cnt+1.
  - If hold_cnt+1 == MAX_HOLD: last <= owner, state <= IDLE; otherwise stay GRANT.
- GRANT edge, req[owner] low (abandon):
  - No write; ack <= 0; last <= owner; state <= IDLE.
- Any edge without a write: ack <= 0.
- Requests from non-owners while in GRANT are ignored until the owner releases. The release always passes through one IDLE cycle, so back-to-back owners have a one-cycle bubble.
- Latency:
  - req rises before edge k in IDLE -> gnt high after edge k.
  - First write at edge k+1 -> q and ack visible after edge k+1.
- Fairness: with all requests held high, the grant order is 0,1,2,...,NUM_REQ-1,0; each owner gets MAX_HOLD writes.
- Data is sampled only at the write edge; data_in changes outside the granted cycles have no effect.
- hold_cnt width: clog2(MAX_HOLD+1); it never wraps because release occurs at MAX_HOLD.

Decomposition:
- Package reg_arb_pkg: state enum (IDLE, GRANT) and the clog2 helper/width constants.
- Sub-module rr_pick: combinational round-robin picker (inputs req and last; outputs winner index and valid).
- The FSM, hold counter and shared q/q_bar register live in the top module.

Test Plan:
- Reset: assert rst 2 cycles with req=4'hF -> q=0, q_bar=4'hF, gnt=0, ack=0, busy=0.
- Single requester: req=4'b0001 held, data0 = 4'hA, then 4'h5, then 4'h3 on successive cycles ->
  - gnt=0001 after edge 1;
  - q=A/5/3 after edges 2/3/4, with ack=0001 each of those cycles and q_bar=~q;
  - IDLE after edge 4; regrant after edge 5.
- All requesting: req=4'hF, MAX_HOLD=3 -> gnt sequence 0001, 0010, 0100, 1000, 0001; 3 acks per owner; 1 IDLE cycle between owners.
- Abandon: requester 2 granted, drops req before the first write -> q unchanged, no ack, IDLE next; then requester 3 (pending) is granted.
- Reset mid-grant: rst asserted on the cycle a write would occur with data 4'h7 -> q=0, gnt=0, ack=0 after that edge; no write.
- MAX_HOLD=1 build with req=4'b0011 -> alternating single writes by 0 and 1, with gnt toggling 0001/0010 separated by IDLE cycles.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and width helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width for a requester number; at least one bit even for tiny configs.
    function automatic int idx_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Hold counter must represent MAX_HOLD itself, so it needs clog2(MAX_HOLD+1) bits.
    function automatic int cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between the requesting producers and the shared-register arbiter.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         q;
    logic [DATA_W-1:0]         q_bar;
    logic                      busy;

    modport master (
        output req, data_in,
        input  gnt, ack, q, q_bar, busy
    );

    modport slave (
        input  req, data_in,
        output gnt, ack, q, q_bar, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default up front so no path can infer a latch.
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((int'(last) + off) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting bounded bursts of writes into one shared q/q_bar register.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 3
) (
    input  logic                clk,
    input  logic                rst,
    reg_write_arbiter_if.slave  bus
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int HOLD_W = cnt_width(MAX_HOLD);

    state_t              state, state_n;
    logic [IDX_W-1:0]    owner, owner_n;
    logic [IDX_W-1:0]    last, last_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [DATA_W-1:0]   q_r, q_n, q_bar_r;
    logic [NUM_REQ-1:0]  gnt_r, gnt_n, ack_r, ack_n;
    logic                busy_r, busy_n;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   wr_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .last    (last),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    assign wr_data = bus.data_in[owner*DATA_W +: DATA_W];

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        q_n     = q_r;
        ack_n   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_n = pick_idx;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (bus.req[owner]) begin
                    q_n    = wr_data;
                    ack_n  = NUM_REQ'(1) << owner;
                    hold_n = hold_cnt + 1'b1;
                    // Burst quota used up: hand priority on to the next requester.
                    if (hold_cnt + 1'b1 == HOLD_W'(MAX_HOLD)) begin
                        last_n  = owner;
                        state_n = IDLE;
                    end
                end else begin
                    last_n  = owner;
                    state_n = IDLE;
                end
            end
        endcase
        gnt_n  = (state_n == GRANT) ? (NUM_REQ'(1) << owner_n) : '0;
        busy_n = (state_n == GRANT);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
            hold_cnt <= '0;
            q_r      <= '0;
            q_bar_r  <= '1;
            gnt_r    <= '0;
            ack_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            q_r      <= q_n;
            q_bar_r  <= ~q_n;
            gnt_r    <= gnt_n;
            ack_r    <= ack_n;
            busy_r   <= busy_n;
        end
    end

    assign bus.q     = q_r;
    assign bus.q_bar = q_bar_r;
    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 4;
    localparam int MH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    reg_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus1 ();

    reg_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_HOLD(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the register, how many writes it has made, who spoke last.
    bit       m_granted;
    int       m_owner;
    int       m_writes;
    int       m_last;
    logic [3:0] m_q;
    logic [3:0] m_ack;

    task automatic model_edge(input bit r, input logic [3:0] rq, input logic [15:0] d);
        if (r) begin
            m_granted = 0; m_owner = 0; m_writes = 0; m_last = NR - 1;
            m_q = 4'h0; m_ack = 4'h0;
        end else if (!m_granted) begin
            m_ack = 4'h0;
            for (int k = 1; k <= NR; k++) begin
                int cand;
                cand = (m_last + k) % NR;
                if (!m_granted && rq[cand]) begin
                    m_granted = 1; m_owner = cand; m_writes = 0;
                end
            end
        end else if (rq[m_owner]) begin
            m_q = d[m_owner*4 +: 4];
            m_ack = 4'(1 << m_owner);
            m_writes++;
            if (m_writes == MH) begin
                m_last = m_owner; m_granted = 0;
            end
        end else begin
            m_ack = 4'h0; m_last = m_owner; m_granted = 0;
        end
    endtask

    task automatic cyc(input bit r, input logic [3:0] rq, input logic [15:0] d);
        rst = r; bus.req = rq; bus.data_in = d;
        @(posedge clk);
        model_edge(r, rq, d);
        #1;
    endtask

    task automatic cyc1(input bit r, input logic [3:0] rq, input logic [15:0] d);
        rst1 = r; bus1.req = rq; bus1.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 4'hF, 16'h1234);
        cyc(1, 4'hF, 16'h1234);
        checks++; if (bus.q !== 4'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", bus.q); end
        checks++; if (bus.q_bar !== 4'hF) begin errors++; $display("FAIL reset_q_bar: got %h expected f", bus.q_bar); end
        checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single();
        logic [3:0] vals [3];
        logic [3:0] eg;
        vals = '{4'hA, 4'h5, 4'h3};
        cyc(0, 4'b0001, 16'h000A);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL single_grant_ack: got %b expected 0000", bus.ack); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 4'b0001, {12'h000, vals[k]});
            eg = (k < 2) ? 4'b0001 : 4'b0000;
            checks++; if (bus.q !== vals[k]) begin errors++; $display("FAIL single_q%0d: got %h expected %h", k, bus.q, vals[k]); end
            checks++; if (bus.q_bar !== ~vals[k]) begin errors++; $display("FAIL single_q_bar%0d: got %h expected %h", k, bus.q_bar, ~vals[k]); end
            checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single_ack%0d: got %b expected 0001", k, bus.ack); end
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL single_gnt%0d: got %b expected %b", k, bus.gnt, eg); end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", bus.busy); end
        cyc(0, 4'b0001, 16'h000F);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_regrant: got %b expected 0001", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL single_regrant_ack: got %b expected 0000", bus.ack); end
        cyc(0, 4'b0000, 16'h000F);
        checks++; if (bus.q !== 4'h3) begin errors++; $display("FAIL single_drop_q: got %h expected 3", bus.q); end
    endtask

    task automatic test_all_request();
        logic [15:0] d;
        logic [3:0]  eg, exp_q;
        int o;
        cyc(1, 4'h0, 16'h0000);
        for (int r = 0; r < NR + 1; r++) begin
            o = r % NR;
            eg = 4'(1 << o);
            cyc(0, 4'hF, 16'($urandom));
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", r, bus.gnt, eg); end
            for (int w = 0; w < MH; w++) begin
                d = 16'($urandom);
                exp_q = d[o*4 +: 4];
                cyc(0, 4'hF, d);
                checks++; if (bus.ack !== eg) begin errors++; $display("FAIL rr_ack%0d_%0d: got %b expected %b", r, w, bus.ack, eg); end
                checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL rr_q%0d_%0d: got %h expected %h", r, w, bus.q, exp_q); end
                checks++;
                if (bus.gnt !== ((w < MH - 1) ? eg : 4'h0)) begin
                    errors++; $display("FAIL rr_gnt%0d_%0d: got %b expected %b", r, w, bus.gnt, (w < MH - 1) ? eg : 4'h0);
                end
            end
        end
    endtask

    task automatic test_abandon();
        cyc(1, 4'h0, 16'h0000);
        cyc(0, 4'b0010, 16'h0060);
        cyc(0, 4'b0010, 16'h0060);
        checks++; if (bus.q !== 4'h6) begin errors++; $display("FAIL abandon_setup_q: got %h expected 6", bus.q); end
        cyc(0, 4'b0000, 16'h0070);
        cyc(0, 4'b1100, 16'h9900);
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL abandon_grant2: got %b expected 0100", bus.gnt); end
        cyc(0, 4'b1000, 16'h9900);
        checks++; if (bus.q !== 4'h6) begin errors++; $display("FAIL abandon_q: got %h expected 6", bus.q); end
        checks++; if (bus.ack !== 4'h0) begin errors++; $display("FAIL abandon_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abandon_busy: got %b expected 0", bus.busy); end
        cyc(0, 4'b1000, 16'hB900);
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL abandon_next_grant: got %b expected 1000", bus.gnt); end
        cyc(0, 4'b1000, 16'hB900);
        checks++; if (bus.q !== 4'hB) begin errors++; $display("FAIL abandon_next_q: got %h expected b", bus.q); end
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL abandon_next_ack: got %b expected 1000", bus.ack); end
    endtask

    task automatic test_reset_mid_grant();
        cyc(1, 4'h0, 16'h0000);
        cyc(0, 4'b0001, 16'h0002);
        cyc(0, 4'b0001, 16'h0002);
        checks++; if (bus.q !== 4'h2) begin errors++; $display("FAIL midrst_setup_q: got %h expected 2", bus.q); end
        cyc(1, 4'b0001, 16'h0007);
        checks++; if (bus.q !== 4'h0) begin errors++; $display("FAIL midrst_q: got %h expected 0", bus.q); end
        checks++; if (bus.q_bar !== 4'hF) begin errors++; $display("FAIL midrst_q_bar: got %h expected f", bus.q_bar); end
        checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL midrst_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.ack !== 4'h0) begin errors++; $display("FAIL midrst_ack: got %b expected 0000", bus.ack); end
        cyc(0, 4'b0000, 16'h0000);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_after_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_random();
        logic [3:0]  rq, eg;
        logic [15:0] d;
        bit          r;
        cyc(1, 4'h0, 16'h0000);
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            rq = 4'($urandom);
            if (m_granted && $urandom_range(0, 3) != 0) rq[m_owner] = 1'b1;
            d  = 16'($urandom);
            cyc(r, rq, d);
            eg = m_granted ? 4'(1 << m_owner) : 4'h0;
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rand_gnt %0d: got %b expected %b", n, bus.gnt, eg); end
            checks++; if (bus.ack !== m_ack) begin errors++; $display("FAIL rand_ack %0d: got %b expected %b", n, bus.ack, m_ack); end
            checks++; if (bus.q !== m_q) begin errors++; $display("FAIL rand_q %0d: got %h expected %h", n, bus.q, m_q); end
            checks++; if (bus.q_bar !== ~m_q) begin errors++; $display("FAIL rand_q_bar %0d: got %h expected %h", n, bus.q_bar, ~m_q); end
            checks++; if (bus.busy !== m_granted) begin errors++; $display("FAIL rand_busy %0d: got %b expected %b", n, bus.busy, m_granted); end
        end
    endtask

    task automatic test_max_hold1();
        logic [15:0] d;
        logic [3:0]  eg, exp_q;
        int who;
        cyc1(1, 4'h0, 16'h0000);
        cyc1(1, 4'h0, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            who = k % 2;
            eg = 4'(1 << who);
            cyc1(0, 4'b0011, 16'($urandom));
            checks++; if (bus1.gnt !== eg) begin errors++; $display("FAIL mh1_grant%0d: got %b expected %b", k, bus1.gnt, eg); end
            checks++; if (bus1.ack !== 4'h0) begin errors++; $display("FAIL mh1_grant_ack%0d: got %b expected 0000", k, bus1.ack); end
            d = 16'($urandom);
            exp_q = d[who*4 +: 4];
            cyc1(0, 4'b0011, d);
            checks++; if (bus1.ack !== eg) begin errors++; $display("FAIL mh1_ack%0d: got %b expected %b", k, bus1.ack, eg); end
            checks++; if (bus1.q !== exp_q) begin errors++; $display("FAIL mh1_q%0d: got %h expected %h", k, bus1.q, exp_q); end
            checks++; if (bus1.gnt !== 4'h0) begin errors++; $display("FAIL mh1_idle%0d: got %b expected 0000", k, bus1.gnt); end
        end
    endtask

    initial begin
        bus.req = '0; bus.data_in = '0;
        bus1.req = '0; bus1.data_in = '0;
        model_edge(1'b1, 4'h0, 16'h0000);
        test_reset();
        test_single();
        test_all_request();
        test_abandon();
        test_reset_mid_grant();
        test_random();
        test_max_hold1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
